i2c_txn_arbiter: RTL and testbench

// Shares one i2c_master_byte_ctrl between NUM_REQ requesters (e.g. PS regs, sensor pollers).

---
 rtl/i2c_txn_arbiter_if.sv | 28 ++
 rtl/i2c_txn_arbiter.sv | 116 +++++++++++
 tb/tb_i2c_txn_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: requester-side and byte-controller-side signals of the transaction arbiter
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 4
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic [NUM_REQ-1:0]       req_valid_i, req_ready_o, req_rw_i;
  logic [NUM_REQ-1:0]       wr_valid_i, wr_ready_o, rd_valid_o, done_o;
  logic [NUM_REQ*7-1:0]     req_addr_i;
  logic [NUM_REQ*LEN_W-1:0] req_len_i;
  logic [NUM_REQ*8-1:0]     wr_data_i;
  logic [7:0]               rd_data_o, din_o, dout_i;
  logic [1:0]               err_o;
  logic                     start_o, stop_o, read_o, write_o, ack_in_o;
  logic                     cmd_ack_i, ack_out_i, al_i;
  modport master (
    input  req_valid_i, req_addr_i, req_rw_i, req_len_i, wr_valid_i, wr_data_i,
           cmd_ack_i, ack_out_i, dout_i, al_i,
    output req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
           start_o, stop_o, read_o, write_o, ack_in_o, din_o
  );
  modport slave (
    output req_valid_i, req_addr_i, req_rw_i, req_len_i, wr_valid_i, wr_data_i,
           cmd_ack_i, ack_out_i, dout_i, al_i,
    input  req_ready_o, wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
           start_o, stop_o, read_o, write_o, ack_in_o, din_o
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte controller, sequencing START+addr, data bytes, STOP
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 4
) (
  input logic              clk_i,
  input logic              rstn_i,
  i2c_txn_arbiter_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ADDR, WFETCH, WDATA, RDATA, STOP, DONE} state_t;
  state_t           r_state, w_state_n;
  logic [GW-1:0]    r_g, r_last, w_g;
  logic             r_rw, w_any, w_accept, w_fetch, w_rd;
  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_n, w_cnt_inc;
  logic [1:0]       r_err, w_err_n;
  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_fetch   = (r_state == WFETCH) && (w_state_n == WDATA);
  assign w_rd      = (r_state == RDATA) && bus.cmd_ack_i && !bus.al_i;
  // round-robin pick: scan downwards so the requester closest after r_last wins
  always_comb begin
    w_g = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (bus.req_valid_i[(int'(r_last) + i) % NUM_REQ]) begin
        w_g = GW'((int'(r_last) + i) % NUM_REQ);
        w_any = 1'b1;
      end
    end
  end
  // next state, byte counter and error code; arbitration loss overrides everything
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_err_n = r_err;
    case (r_state)
      IDLE: if (w_any) begin
        w_state_n = ADDR;
        w_cnt_n = '0;
        w_err_n = 2'b00;
      end
      ADDR: if (bus.cmd_ack_i) begin
        w_state_n = (bus.ack_out_i || r_len == '0) ? STOP : r_rw ? RDATA : WFETCH;
        w_err_n = bus.ack_out_i ? 2'b01 : 2'b00;
      end
      WFETCH: if (bus.wr_valid_i[r_g]) w_state_n = WDATA;
      WDATA: if (bus.cmd_ack_i) begin
        w_cnt_n = w_cnt_inc;
        w_state_n = (bus.ack_out_i || w_cnt_inc == r_len) ? STOP : WFETCH;
        w_err_n = bus.ack_out_i ? 2'b10 : r_err;
      end
      RDATA: if (bus.cmd_ack_i) begin
        w_cnt_n = w_cnt_inc;
        w_state_n = (w_cnt_inc == r_len) ? STOP : RDATA;
      end
      STOP: if (bus.cmd_ack_i) w_state_n = DONE;
      DONE: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (bus.al_i && r_state != IDLE && r_state != DONE) begin
      w_state_n = DONE;
      w_err_n = 2'b11;
    end
  end
  // state, transaction context and all registered outputs; commands follow the next state
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_g <= '0;
      r_last <= GW'(NUM_REQ - 1);
      r_rw <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= '0;
      bus.req_ready_o <= '0;
      bus.wr_ready_o <= '0;
      bus.rd_valid_o <= '0;
      bus.rd_data_o <= '0;
      bus.done_o <= '0;
      bus.err_o <= '0;
      bus.start_o <= 1'b0;
      bus.stop_o <= 1'b0;
      bus.read_o <= 1'b0;
      bus.write_o <= 1'b0;
      bus.ack_in_o <= 1'b0;
      bus.din_o <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_err <= w_err_n;
      bus.start_o <= w_state_n == ADDR;
      bus.write_o <= (w_state_n == ADDR) || (w_state_n == WDATA);
      bus.read_o <= w_state_n == RDATA;
      bus.stop_o <= w_state_n == STOP;
      bus.ack_in_o <= (w_state_n == RDATA) && (w_cnt_n == r_len - LEN_W'(1));
      bus.req_ready_o <= w_accept ? NUM_REQ'(1) << w_g : '0;
      bus.wr_ready_o <= w_fetch ? NUM_REQ'(1) << r_g : '0;
      bus.rd_valid_o <= w_rd ? NUM_REQ'(1) << r_g : '0;
      bus.done_o <= (r_state == DONE) ? NUM_REQ'(1) << r_g : '0;
      if (w_accept) begin
        r_g <= w_g;
        r_rw <= bus.req_rw_i[w_g];
        r_len <= bus.req_len_i[w_g*LEN_W +: LEN_W];
        bus.din_o <= {bus.req_addr_i[w_g*7 +: 7], bus.req_rw_i[w_g]};
      end
      if (w_fetch) bus.din_o <= bus.wr_data_i[r_g*8 +: 8];
      if (w_rd) bus.rd_data_o <= bus.dout_i;
      if (r_state == DONE) begin
        bus.err_o <= r_err;
        r_last <= r_g;
      end
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: randomized transactions against a command-sequence reference model
module tb_i2c_txn_arbiter;
  localparam int NR = 2;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);
  logic clk = 1'b0;
  logic rst_main = 1'b0;
  logic rst_mid = 1'b0;
  logic rstn;
  assign rstn = rst_main & ~rst_mid;
  always #5 clk = ~clk;
  i2c_txn_arbiter_if #(.NUM_REQ(NR), .MAX_LEN(ML)) bus ();
  i2c_txn_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
  logic [30:0] all_out;
  assign all_out = {bus.req_ready_o, bus.wr_ready_o, bus.rd_valid_o, bus.rd_data_o, bus.done_o,
                    bus.err_o, bus.start_o, bus.stop_o, bus.read_o, bus.write_o, bus.ack_in_o, bus.din_o};
  int n_chk = 0;
  int n_fail = 0;
  int nack_at = 0, al_at = 0, rst_at = 0, cmd_idx = 0, exp_last = NR - 1;
  int obs_k[$], obs_d[$], obs_a[$], rd_q[$];
  logic rst_flag = 1'b0;
  logic [7:0] wd [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // byte-controller model: logs each command (1=S 2=W 3=R 4=P), then acks, NACKs, loses arbitration or resets
  initial begin
    int k;
    bus.cmd_ack_i = 1'b0;
    bus.ack_out_i = 1'b0;
    bus.dout_i = '0;
    bus.al_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && (bus.start_o | bus.stop_o | bus.read_o | bus.write_o)) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        k = bus.start_o ? 1 : bus.stop_o ? 4 : bus.read_o ? 3 : 2;
        cmd_idx++;
        obs_k.push_back(k);
        obs_d.push_back(int'(bus.din_o));
        obs_a.push_back(int'(bus.ack_in_o));
        if (cmd_idx == al_at) begin
          bus.al_i = 1'b1;
          @(negedge clk);
          bus.al_i = 1'b0;
        end else if (cmd_idx == rst_at) begin
          rst_mid = 1'b1;
          @(negedge clk);
          rst_mid = 1'b0;
          rst_flag = 1'b1;
        end else begin
          bus.cmd_ack_i = 1'b1;
          bus.ack_out_i = (cmd_idx == nack_at);
          bus.dout_i = 8'($urandom);
          if (k == 3) rd_q.push_back(int'(bus.dout_i));
          @(negedge clk);
          bus.cmd_ack_i = 1'b0;
          bus.ack_out_i = 1'b0;
        end
      end
    end
  end

  // one transaction from requester r; nk/ak/rk = command index that gets NACK / arb-lost / reset (0 = none)
  task automatic run_txn(input int r, input logic [6:0] addr, input logic rw, input int len,
                         input int nk, input int ak, input int rk);
    int ek[$], ed[$], ea[$], got_rd[$];
    int err = 0, nw = 0, nr = 0, wi = 0, reqs = 0, cyc = 0;
    logic seen_done = 1'b0;
    logic [NR-1:0] dn = '0;
    logic [1:0] de = '0;
    ek.push_back(1); ed.push_back(int'({addr, rw})); ea.push_back(0);
    if (nk == 1) err = 1;
    else for (int k = 0; k < len; k++) begin
      ek.push_back(rw ? 3 : 2); ed.push_back(int'(wd[k])); ea.push_back(int'(rw && k == len - 1));
      if (!rw && nk == k + 2) begin
        err = 2;
        break;
      end
    end
    ek.push_back(4); ed.push_back(0); ea.push_back(0);
    if (ak > 0) err = 3;
    while ((ak > 0 && ek.size() > ak) || (rk > 0 && ek.size() > rk)) begin
      void'(ek.pop_back()); void'(ed.pop_back()); void'(ea.pop_back());
    end
    foreach (ek[i]) begin
      nw += int'(ek[i] == 2);
      nr += int'(ek[i] == 3);
    end
    if ((ak > 0 || rk > 0) && ek[$] == 3) nr--;
    nack_at = nk; al_at = ak; rst_at = rk; cmd_idx = 0; rst_flag = 1'b0;
    obs_k.delete(); obs_d.delete(); obs_a.delete(); rd_q.delete();
    bus.req_addr_i[r*7 +: 7] = addr;
    bus.req_rw_i[r] = rw;
    bus.req_len_i[r*LW +: LW] = LW'(len);
    bus.wr_data_i[r*8 +: 8] = wd[0];
    bus.wr_valid_i[r] = !rw && len > 0;
    bus.req_valid_i[r] = 1'b1;
    while (!seen_done && !rst_flag && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready_o != 0) begin
        reqs++;
        check("req_ready", 32'(bus.req_ready_o), 1 << r);
        bus.req_valid_i[r] = 1'b0;
      end
      if (bus.wr_ready_o != 0) begin
        check("wr_ready", 32'(bus.wr_ready_o), 1 << r);
        wi++;
        if (wi < len) bus.wr_data_i[r*8 +: 8] = wd[wi];
        else bus.wr_valid_i[r] = 1'b0;
      end
      if (bus.rd_valid_o != 0) begin
        check("rd_valid", 32'(bus.rd_valid_o), 1 << r);
        got_rd.push_back(int'(bus.rd_data_o));
      end
      if (bus.done_o != 0) begin
        seen_done = 1'b1;
        dn = bus.done_o;
        de = bus.err_o;
      end
    end
    bus.req_valid_i[r] = 1'b0;
    bus.wr_valid_i[r] = 1'b0;
    check("req_accepts", reqs, 1);
    check("cmd_count", obs_k.size(), ek.size());
    for (int i = 0; i < ek.size() && i < obs_k.size(); i++) begin
      check("cmd_kind", obs_k[i], ek[i]);
      if (ek[i] <= 2) check("cmd_din", obs_d[i], ed[i]);
      if (ek[i] == 3) check("ack_in", obs_a[i], ea[i]);
    end
    check("wr_fetches", wi, nw);
    check("rd_count", got_rd.size(), nr);
    for (int i = 0; i < got_rd.size() && i < rd_q.size(); i++) check("rd_data", got_rd[i], rd_q[i]);
    if (rk > 0) begin
      check("reset_seen", 32'(rst_flag), 1);
      check("no_done_on_reset", 32'(seen_done), 0);
      check("outs_after_reset", 32'(all_out), 0);
      exp_last = NR - 1;
    end else begin
      check("done_seen", 32'(seen_done), 1);
      check("done_onehot", 32'(dn), 1 << r);
      check("err", 32'(de), err);
      exp_last = r;
    end
    repeat (2) @(negedge clk);
  endtask

  // both requesters always pending with 1-byte writes: grants must alternate
  task automatic fairness();
    int cnt [2] = '{0, 0};
    int dones = 0, cyc = 0, g = 0;
    nack_at = 0; al_at = 0; rst_at = 0; cmd_idx = 0;
    for (int r = 0; r < NR; r++) begin
      bus.req_addr_i[r*7 +: 7] = 7'(8'h30 + r);
      bus.req_rw_i[r] = 1'b0;
      bus.req_len_i[r*LW +: LW] = LW'(1);
      bus.wr_data_i[r*8 +: 8] = 8'(8'h90 + r);
    end
    bus.wr_valid_i = '1;
    bus.req_valid_i = '1;
    while (dones < 8 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready_o != 0) begin
        g = bus.req_ready_o[1] ? 1 : 0;
        check("rr_grant", 32'(bus.req_ready_o), 1 << ((exp_last + 1) % NR));
        cnt[g]++;
      end
      if (bus.done_o != 0) begin
        dones++;
        check("rr_done", 32'(bus.done_o), 1 << g);
        exp_last = g;
      end
    end
    bus.req_valid_i = '0;
    bus.wr_valid_i = '0;
    check("rr_done_count", dones, 8);
    check("rr_req0_count", cnt[0], 4);
    check("rr_req1_count", cnt[1], 4);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r, len, nk, ak, ncmd;
    logic rw;
    logic [6:0] addr;
    bus.req_valid_i = '0;
    bus.req_addr_i = '0;
    bus.req_rw_i = '0;
    bus.req_len_i = '0;
    bus.wr_valid_i = '0;
    bus.wr_data_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(all_out), 0);
    rst_main = 1'b1;
    @(negedge clk);
    wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'h00; wd[3] = 8'h00;
    run_txn(0, 7'h50, 1'b0, 2, 0, 0, 0);
    run_txn(1, 7'h48, 1'b1, 3, 0, 0, 0);
    fairness();
    run_txn(0, 7'h21, 1'b0, 2, 1, 0, 0);
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    run_txn(1, 7'h33, 1'b0, 3, 2, 0, 0);
    run_txn(0, 7'h4C, 1'b1, 3, 0, 3, 0);
    run_txn(1, 7'h5A, 1'b0, 3, 0, 0, 3);
    run_txn(0, 7'h12, 1'b0, 0, 0, 0, 0);
    run_txn(1, 7'h13, 1'b1, 0, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, NR - 1);
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(0, ML);
      addr = 7'($urandom);
      for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
      nk = 0;
      if ($urandom_range(0, 4) == 0) nk = rw ? 1 : $urandom_range(1, len + 1);
      ncmd = (nk == 1) ? 2 : (nk > 1) ? nk + 1 : len + 2;
      ak = ($urandom_range(0, 5) == 0) ? $urandom_range(1, ncmd) : 0;
      run_txn(r, addr, rw, len, nk, ak, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
